// File: rtl/wb_mem_slave_if.sv
// Wishbone classic bus bundle between a single master and a single slave.
// Ports: cyc/stb/we/adr/sel/dat_ms flow master->slave; ack/err/dat_sm flow slave->master.
// The master modport drives requests; the slave modport drives responses.
interface wb_bus_t;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic        ack;
  logic        err;
  logic [31:0] dat_sm;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms,
    input  ack, err, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms,
    output ack, err, dat_sm
  );
endinterface

// File: rtl/wb_mem_slave.sv
// Wishbone classic memory slave: MEM_WORDS x 32-bit with byte-lane writes.
// Latency: a request sampled in cycle N is answered (ack or err) in cycle N+1+WAIT_STATES.
// Backpressure: the master holds cyc/stb until ack/err; dropping either before then aborts.
// Ports: clk, rstn_i (async active-low), wb_bus (slave modport of wb_bus_t).
module wb_mem_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic   clk,
  input  logic   rstn_i,
  wb_bus_t.slave wb_bus
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Byte span of the window, kept 33 bits wide so a 4 GiB window still fits.
  localparam logic [32:0] SPAN      = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Storage: deliberately not reset.
  logic [31:0] mem [MEM_WORDS];

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] wdat_q;
  logic [AW-1:0] idx_q;
  logic        inr_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdat_q;

  logic        req;
  logic [32:0] diff;
  logic        in_range;
  logic [AW-1:0] idx;

  assign req = wb_bus.cyc & wb_bus.stb;

  // 33-bit subtraction: an address below the base borrows into bit 32 and
  // lands far above SPAN, so one unsigned compare covers both window edges.
  assign diff     = {1'b0, wb_bus.adr} - {1'b0, BASE_ADDR};
  assign in_range = (diff < SPAN);
  assign idx      = diff[AW+1:2];

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      we_q   <= 1'b0;
      sel_q  <= 4'd0;
      wdat_q <= 32'd0;
      idx_q  <= '0;
      inr_q  <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          rdat_q <= 32'd0;
          if (req) begin
            we_q   <= wb_bus.we;
            sel_q  <= wb_bus.sel;
            wdat_q <= wb_bus.dat_ms;
            idx_q  <= idx;
            inr_q  <= in_range;
            if (WAIT_STATES == 0) begin
              // No wait states: the response is built straight from the bus.
              state  <= RESP;
              ack_q  <= in_range;
              err_q  <= ~in_range;
              rdat_q <= (in_range && !wb_bus.we) ? mem[idx] : 32'd0;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end

        WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state  <= RESP;
            ack_q  <= inr_q;
            err_q  <= ~inr_q;
            rdat_q <= (inr_q && !we_q) ? mem[idx_q] : 32'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          // One response cycle only; a new request is not sampled here.
          state  <= IDLE;
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          rdat_q <= 32'd0;
        end

        default: begin
          state  <= IDLE;
          cnt    <= 4'd0;
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          rdat_q <= 32'd0;
        end
      endcase
    end
  end

  // Write commits on the edge that ends the RESP cycle, only if the master
  // is still requesting; err responses never reach here because inr_q is 0.
  always_ff @(posedge clk) begin
    if (state == RESP && inr_q && we_q && req) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdat_q[8*i +: 8];
        end
      end
    end
  end

  // Response strobes are qualified by the live request so a master that
  // withdraws during RESP sees neither ack nor err.
  assign wb_bus.ack    = ack_q & req;
  assign wb_bus.err    = err_q & req;
  assign wb_bus.dat_sm = wb_bus.ack ? rdat_q : 32'd0;

endmodule

// File: tb/tb_wb_mem_slave.sv
module tb_wb_mem_slave;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Bench-side master; routed to the instance selected by cur
  // (instance g has WAIT_STATES = g).
  logic [1:0]  cur = 2'd1;
  logic        b_cyc = 1'b0, b_stb = 1'b0, b_we = 1'b0;
  logic [31:0] b_adr = 32'd0, b_dat = 32'd0;
  logic [3:0]  b_sel = 4'd0;

  logic [3:0]  ack_v, err_v;
  logic [31:0] dat_v [4];
  logic        r_ack, r_err;
  logic [31:0] r_dat;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_bus_t bus ();
    assign bus.cyc    = (cur == g) ? b_cyc : 1'b0;
    assign bus.stb    = (cur == g) ? b_stb : 1'b0;
    assign bus.we     = b_we;
    assign bus.adr    = b_adr;
    assign bus.sel    = b_sel;
    assign bus.dat_ms = b_dat;
    assign ack_v[g]   = bus.ack;
    assign err_v[g]   = bus.err;
    assign dat_v[g]   = bus.dat_sm;
    wb_mem_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(g)) u_dut (
      .clk(clk), .rstn_i(rstn), .wb_bus(bus.slave)
    );
  end

  always_comb begin
    r_ack = ack_v[cur];
    r_err = err_v[cur];
    r_dat = dat_v[cur];
  end

  int n_checks = 0;
  int n_errs   = 0;
  int cyc_n    = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc_n);
    end
  endtask

  // Transaction-level reference: a request accepted in cycle c is answered
  // in cycle c+1+ws; the slave is free again the cycle after an answer or
  // after the master withdraws. Reset forgets anything pending.
  logic [31:0] mmem [4][1024];
  bit          pend = 0;
  int          due = 0, free_from = 0, p_idx = 0;
  bit          p_we = 0, p_inr = 0;
  logic [3:0]  p_sel = 0;
  logic [31:0] p_dat = 0;

  always @(negedge clk) begin : model
    logic e_ack, e_err, live;
    logic [31:0] e_dat;
    e_ack = 1'b0; e_err = 1'b0; e_dat = 32'd0;
    live  = b_cyc & b_stb;
    if (!rstn) begin
      pend = 0;
      free_from = cyc_n;
    end else if (pend) begin
      if (!live) begin
        pend = 0;
        free_from = cyc_n + 1;
      end else if (cyc_n == due) begin
        if (p_inr) begin
          e_ack = 1'b1;
          if (p_we) begin
            for (int i = 0; i < 4; i++)
              if (p_sel[i]) mmem[cur][p_idx][8*i +: 8] = p_dat[8*i +: 8];
          end else begin
            e_dat = mmem[cur][p_idx];
          end
        end else begin
          e_err = 1'b1;
        end
        pend = 0;
        free_from = cyc_n + 1;
      end
    end else if (live && cyc_n >= free_from) begin
      pend  = 1;
      p_we  = b_we;
      p_sel = b_sel;
      p_dat = b_dat;
      p_inr = (b_adr < 32'd4096);
      p_idx = int'(b_adr / 4) % 1024;
      due   = cyc_n + 1 + int'(cur);
    end
    chk("cmp_ack", 32'(r_ack), 32'(e_ack));
    chk("cmp_err", 32'(r_err), 32'(e_err));
    chk("cmp_dat", r_dat, e_dat);
  end

  task automatic start_req(input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
    @(posedge clk); #1;
    b_cyc = 1'b1; b_stb = 1'b1; b_we = we; b_adr = adr; b_sel = sel; b_dat = dat;
  endtask

  task automatic wait_resp(output int at, output logic was_ack, output logic [31:0] d);
    at = -1; was_ack = 1'b0; d = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (r_ack || r_err) begin
        at = cyc_n; was_ack = r_ack; d = r_dat;
        break;
      end
    end
    if (at < 0) begin
      n_checks++; n_errs++;
      $display("FAIL resp_timeout: got no ack/err expected one within 40 cycles");
    end
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output int lat, output logic was_ack,
                      output logic [31:0] rd);
    int st, at;
    start_req(we, adr, sel, dat);
    st = cyc_n;
    wait_resp(at, was_ack, rd);
    lat = at - st;
    end_req();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, st, a1, a2, hits;
    logic ok;
    logic [31:0] rd;
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 1024; w++) mmem[k][w] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(r_ack), 32'd0);
    chk("reset_err", 32'(r_err), 32'd0);
    chk("reset_dat", r_dat, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // WAIT_STATES=1: write then read back, latency 2.
    cur = 2'd1;
    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, ok, rd);
    chk("ws1_wr_lat", 32'(lat), 32'd2);
    chk("ws1_wr_ack", 32'(ok), 32'd1);
    xfer(1'b0, 32'h10, 4'h0, 32'h0, lat, ok, rd);
    chk("ws1_rd_lat", 32'(lat), 32'd2);
    chk("ws1_rd_dat", rd, 32'hDEADBEEF);

    // Byte lanes 0 and 2 only.
    xfer(1'b1, 32'h10, 4'b0101, 32'h11223344, lat, ok, rd);
    xfer(1'b0, 32'h12, 4'h0, 32'h0, lat, ok, rd);
    chk("lanes_dat", rd, 32'hDE22BE44);

    // Bus changes after the request is latched are ignored.
    xfer(1'b1, 32'h18, 4'hF, 32'h0BADF00D, lat, ok, rd);
    start_req(1'b1, 32'h14, 4'hF, 32'hA5A5A5A5);
    @(posedge clk); #1;
    b_adr = 32'h18; b_dat = 32'h0; b_sel = 4'h0; b_we = 1'b0;
    wait_resp(a1, ok, rd);
    end_req();
    xfer(1'b0, 32'h14, 4'h0, 32'h0, lat, ok, rd);
    chk("latch_wr_dat", rd, 32'hA5A5A5A5);
    xfer(1'b0, 32'h18, 4'h0, 32'h0, lat, ok, rd);
    chk("latch_other_dat", rd, 32'h0BADF00D);

    // Window edges: last word acks, first word past the end errs.
    xfer(1'b1, 32'h0, 4'hF, 32'h01234567, lat, ok, rd);
    xfer(1'b1, 32'hFFC, 4'hF, 32'h89ABCDEF, lat, ok, rd);
    chk("last_word_ack", 32'(ok), 32'd1);
    xfer(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, lat, ok, rd);
    chk("oor_wr_err", 32'(ok), 32'd0);
    chk("oor_wr_lat", 32'(lat), 32'd2);
    xfer(1'b0, 32'h1004, 4'h0, 32'h0, lat, ok, rd);
    chk("oor_rd_dat", rd, 32'd0);
    xfer(1'b0, 32'h0, 4'h0, 32'h0, lat, ok, rd);
    chk("word0_kept", rd, 32'h01234567);
    xfer(1'b0, 32'hFFC, 4'h0, 32'h0, lat, ok, rd);
    chk("last_word_dat", rd, 32'h89ABCDEF);

    // WAIT_STATES=3: abort by dropping stb in cycle 2.
    cur = 2'd3;
    xfer(1'b1, 32'h20, 4'hF, 32'h55AA55AA, lat, ok, rd);
    chk("ws3_lat", 32'(lat), 32'd4);
    start_req(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
    @(posedge clk); #1;
    @(posedge clk); #1 b_stb = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (r_ack || r_err) hits++;
    end
    chk("abort_no_resp", 32'(hits), 32'd0);
    end_req();
    xfer(1'b0, 32'h20, 4'h0, 32'h0, lat, ok, rd);
    chk("abort_mem_kept", rd, 32'h55AA55AA);

    // WAIT_STATES=2: reset in cycle 1 of a write.
    cur = 2'd2;
    xfer(1'b1, 32'h30, 4'hF, 32'h13579BDF, lat, ok, rd);
    start_req(1'b1, 32'h30, 4'hF, 32'hFFFFFFFF);
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(r_ack), 32'd0);
    chk("rst_mid_err", 32'(r_err), 32'd0);
    chk("rst_mid_dat", r_dat, 32'd0);
    b_cyc = 1'b0; b_stb = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 32'h30; b_sel = 4'h0;
    st = cyc_n;
    wait_resp(a1, ok, rd);
    end_req();
    chk("rst_release_lat", 32'(a1 - st), 32'd3);
    chk("rst_mem_kept", rd, 32'h13579BDF);

    // WAIT_STATES=0: back-to-back reads with stb held high.
    cur = 2'd0;
    xfer(1'b1, 32'h40, 4'hF, 32'h0F0F0F0F, lat, ok, rd);
    chk("ws0_lat", 32'(lat), 32'd1);
    xfer(1'b1, 32'h44, 4'hF, 32'hF0F0F0F0, lat, ok, rd);
    start_req(1'b0, 32'h40, 4'h0, 32'h0);
    st = cyc_n;
    wait_resp(a1, ok, rd);
    chk("b2b_first_dat", rd, 32'h0F0F0F0F);
    @(posedge clk); #1 b_adr = 32'h44;
    wait_resp(a2, ok, rd);
    end_req();
    chk("b2b_first_cyc", 32'(a1 - st), 32'd1);
    chk("b2b_second_cyc", 32'(a2 - st), 32'd3);
    chk("b2b_second_dat", rd, 32'hF0F0F0F0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
